// File: rtl/flash_stream_sequencer_pkg.sv
// Shared definitions for the flash stream sequencer and the SPI flash controller.
//   FLASH_WORD_BYTES : bytes per flash word (must match the controller)
//   DATA_WIDTH_BITS  : flash word width in bits
//   seq_state_t      : sequencer FSM states
package flash_stream_sequencer_pkg;

  localparam int unsigned FLASH_WORD_BYTES = 4;
  localparam int unsigned DATA_WIDTH_BITS  = FLASH_WORD_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_WAIT,
    ST_HOLD,
    ST_STOP,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO buffering fetched flash words for the downstream consumer.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empties the FIFO; takes priority over push and pop
//   push, push_data : write one word (caller guarantees not full)
//   pop, pop_data   : remove the head word (caller guarantees not empty);
//                     pop_data always shows the head word
//   count, empty, full : occupancy status
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count_q;

  // Pointers wrap naturally modulo DEPTH (DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW + 1)'(DEPTH));

endmodule

// File: rtl/flash_stream_sequencer.sv
// Streams len_words contiguous words from flash starting at base_addr by
// sequencing start/continue/stop pulses to the SPI flash controller, and
// buffers the words in a FIFO feeding a valid/ready consumer.
//   clk, rst          : clock, asynchronous active-high reset
//   base_addr, len_words, restart : stream setup, sampled on restart pulse
//   ctl_addr, ctl_start_read, ctl_stop_read, ctl_continue_read : to controller
//   ctl_data, ctl_busy : from controller
//   out_data, out_valid, out_ready : FIFO head, consumer handshake
//   done              : all words of the stream fetched (until next restart)
module flash_stream_sequencer
  import flash_stream_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_BYTES = FLASH_WORD_BYTES,
  parameter int unsigned ADDR_BITS        = 16,
  parameter int unsigned LEN_BITS         = 12,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_BITS-1:0]          base_addr,
  input  logic [LEN_BITS-1:0]           len_words,
  input  logic                          restart,
  output logic [ADDR_BITS-1:0]          ctl_addr,
  output logic                          ctl_start_read,
  output logic                          ctl_stop_read,
  output logic                          ctl_continue_read,
  input  logic [DATA_WIDTH_BYTES*8-1:0] ctl_data,
  input  logic                          ctl_busy,
  output logic [DATA_WIDTH_BYTES*8-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done
);

  localparam int unsigned DW   = DATA_WIDTH_BYTES * 8;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t state, state_next;

  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  remaining_q;
  logic                 pending_q;

  logic                 load_cfg;
  logic                 pend_set;
  logic                 pend_clr;
  logic                 push_word;
  logic                 start_pulse;
  logic                 cont_pulse;

  logic [CNTW-1:0]      fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_room;

  assign fifo_room = (fifo_count < CNTW'(FIFO_DEPTH));

  stream_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (restart),
    .push      (push_word && !fifo_full),
    .push_data (ctl_data),
    .pop       (out_valid && out_ready),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (load_cfg) begin
        addr_q      <= base_addr;
        remaining_q <= len_words;
      end else if (push_word && remaining_q != '0) begin
        remaining_q <= remaining_q - LEN_BITS'(1);
      end
      if (pend_clr)      pending_q <= 1'b0;
      else if (pend_set) pending_q <= 1'b1;
    end
  end

  // A restart while the controller is mid-transfer (ARM/WAIT) cannot abort
  // the transfer; it is remembered in pending_q and the returning word is
  // dropped. START/HOLD have nothing in flight and go straight to STOP.
  // The issue pulses are gated by restart so no new transfer starts in the
  // cycle the stream is being torn down.
  always_comb begin
    state_next  = state;
    load_cfg    = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    push_word   = 1'b0;
    start_pulse = 1'b0;
    cont_pulse  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (restart) begin
          load_cfg   = 1'b1;
          state_next = (len_words == '0) ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        if (restart) begin
          load_cfg   = 1'b1;
          pend_set   = 1'b1;
          state_next = ST_STOP;
        end else if (fifo_room) begin
          start_pulse = 1'b1;
          state_next  = ST_ARM;
        end
      end
      ST_ARM: begin
        if (restart) begin
          load_cfg = 1'b1;
          pend_set = 1'b1;
        end
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (restart) begin
          load_cfg = 1'b1;
          pend_set = 1'b1;
        end
        if (!ctl_busy) begin
          if (pending_q || restart) begin
            state_next = ST_STOP;
          end else begin
            push_word  = 1'b1;
            state_next = (remaining_q <= LEN_BITS'(1)) ? ST_STOP : ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (restart) begin
          load_cfg   = 1'b1;
          pend_set   = 1'b1;
          state_next = ST_STOP;
        end else if (fifo_room) begin
          cont_pulse = 1'b1;
          state_next = ST_ARM;
        end
      end
      ST_STOP: begin
        pend_clr = 1'b1;
        if (restart) begin
          load_cfg   = 1'b1;
          state_next = (len_words == '0) ? ST_DONE : ST_START;
        end else if (pending_q && remaining_q != '0) begin
          state_next = ST_START;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl_start_read    = start_pulse;
    ctl_continue_read = cont_pulse;
    ctl_stop_read     = (state == ST_IDLE) || (state == ST_STOP) || (state == ST_DONE);
    done              = (state == ST_DONE);
  end

  assign ctl_addr  = addr_q;
  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_flash_stream_sequencer.sv
`timescale 1ns/1ps
module tb_flash_stream_sequencer;
  import flash_stream_sequencer_pkg::*;

  localparam int unsigned AB = 16;
  localparam int unsigned LB = 12;
  localparam int unsigned DW = DATA_WIDTH_BITS;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AB-1:0] base_addr;
  logic [LB-1:0] len_words;
  logic          restart;
  logic [AB-1:0] ctl_addr;
  logic          ctl_start_read, ctl_stop_read, ctl_continue_read;
  logic [DW-1:0] ctl_data;
  logic          ctl_busy;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, done;

  always #5 clk = ~clk;

  flash_stream_sequencer #(
    .DATA_WIDTH_BYTES (4),
    .ADDR_BITS        (AB),
    .LEN_BITS         (LB),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .base_addr         (base_addr),
    .len_words         (len_words),
    .restart           (restart),
    .ctl_addr          (ctl_addr),
    .ctl_start_read    (ctl_start_read),
    .ctl_stop_read     (ctl_stop_read),
    .ctl_continue_read (ctl_continue_read),
    .ctl_data          (ctl_data),
    .ctl_busy          (ctl_busy),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .done              (done)
  );

  // Controller model: busy rises the cycle after a pulse, stays high LAT
  // cycles, then falls presenting {start address, word index}.
  logic [15:0]  m_addr, m_idx;
  int unsigned  m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_busy <= 1'b0;
      ctl_data <= '0;
      m_addr   <= '0;
      m_idx    <= '0;
      m_cnt    <= 0;
    end else if (ctl_start_read) begin
      ctl_busy <= 1'b1;
      m_cnt    <= LAT;
      m_addr   <= ctl_addr;
      m_idx    <= '0;
    end else if (ctl_continue_read) begin
      ctl_busy <= 1'b1;
      m_cnt    <= LAT;
      m_idx    <= m_idx + 16'd1;
    end else if (ctl_busy) begin
      if (m_cnt == 1) begin
        ctl_busy <= 1'b0;
        ctl_data <= {m_addr, m_idx};
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Monitor, sampled mid-cycle.
  int unsigned   n_start = 0, n_cont = 0, n_stop = 0, nwords = 0;
  logic [DW-1:0] words [0:255];
  logic          excl_bad = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ctl_start_read)    n_start++;
      if (ctl_continue_read) n_cont++;
      if (ctl_stop_read)     n_stop++;
      if (ctl_stop_read && (ctl_continue_read || ctl_start_read)) excl_bad = 1'b1;
      if (out_valid && out_ready && !restart && nwords < 256) begin
        words[nwords] = out_data;
        nwords++;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic do_restart(input logic [AB-1:0] a, input logic [LB-1:0] l);
    base_addr = a;
    len_words = l;
    restart   = 1'b1;
    step();
    restart   = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int unsigned s0, c0, p0, w0;
  int n;

  initial begin
    base_addr = '0;
    len_words = '0;
    restart   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_stop",  ctl_stop_read, 1);
    check("rst_start", ctl_start_read, 0);
    check("rst_cont",  ctl_continue_read, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done",  done, 0);
    check("rst_addr",  ctl_addr, 0);
    rst = 1'b0;
    step();

    // Basic 3-word stream.
    out_ready = 1'b1;
    do_restart(16'h1200, 12'd3);
    check("b_lat_start", ctl_start_read, 1);
    check("b_addr", ctl_addr, 16'h1200);
    s0 = n_start; c0 = n_cont; p0 = n_stop; w0 = nwords;
    wait_done("b_done", 100);
    check("b_stop_cycles", n_stop - p0, 1);
    repeat (3) step();
    check("b_starts", n_start - s0, 1);
    check("b_conts", n_cont - c0, 2);
    check("b_nwords", nwords - w0, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b_word%0d", i), words[w0 + i], 32'h1200_0000 + i);

    // Zero-length stream.
    s0 = n_start; c0 = n_cont;
    do_restart(16'h5000, 12'd0);
    check("c_done", done, 1);
    check("c_addr", ctl_addr, 16'h5000);
    repeat (5) step();
    check("c_starts", n_start - s0, 0);
    check("c_conts", n_cont - c0, 0);
    check("c_valid", out_valid, 0);
    check("c_stop", ctl_stop_read, 1);

    // Restart while a word is in flight.
    out_ready = 1'b0;
    do_restart(16'h3400, 12'd5);
    n = 0;
    while (!ctl_continue_read && n < 50) begin
      step();
      n++;
    end
    check("d_hold_cont", ctl_continue_read, 1);
    step();
    step();
    check("d_valid_before", out_valid, 1);
    w0 = nwords;
    out_ready = 1'b1;
    do_restart(16'h7700, 12'd2);
    check("d_flushed", out_valid, 0);
    n = 0;
    while (!ctl_start_read && n < 30) begin
      step();
      n++;
    end
    check("d_restart_start", ctl_start_read, 1);
    check("d_restart_addr", ctl_addr, 16'h7700);
    check("d_dropped", out_valid, 0);
    wait_done("d_done", 100);
    repeat (3) step();
    check("d_nwords", nwords - w0, 2);
    check("d_word0", words[w0], 32'h7700_0000);
    check("d_word1", words[w0 + 1], 32'h7700_0001);

    // Back-pressure: FIFO fills, then one pop allows exactly one more fetch.
    out_ready = 1'b0;
    do_restart(16'h0A00, 12'd10);
    s0 = n_start; c0 = n_cont; w0 = nwords;
    repeat (60) step();
    check("e_starts", n_start - s0, 1);
    check("e_conts_full", n_cont - c0, 3);
    check("e_valid", out_valid, 1);
    check("e_head", out_data, 32'h0A00_0000);
    check("e_not_done", done, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (40) step();
    check("e_conts_one_more", n_cont - c0, 4);
    out_ready = 1'b1;
    wait_done("e_done", 300);
    repeat (6) step();
    check("e_nwords", nwords - w0, 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("e_word%0d", i), words[w0 + i], 32'h0A00_0000 + i);

    // Asynchronous reset while parked in HOLD.
    out_ready = 1'b0;
    do_restart(16'h0B00, 12'd10);
    repeat (40) step();
    check("f_in_hold", ctl_stop_read, 0);
    #2;
    rst = 1'b1;
    #1;
    check("f_stop",  ctl_stop_read, 1);
    check("f_valid", out_valid, 0);
    check("f_done",  done, 0);
    check("f_start", ctl_start_read, 0);
    check("f_cont",  ctl_continue_read, 0);
    check("f_addr",  ctl_addr, 0);
    step();
    rst = 1'b0;
    step();

    check("excl_stop_pulse", excl_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
